// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, owner encoding and the
// default WAIT timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_arb_pick.sv
// Owner selection between fetch and data requesters. MEM_ARB_RR_EN selects
// round-robin on conflict; otherwise the data side always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output owner_t owner
);

`ifdef MEM_ARB_RR_EN
  // On conflict the side that did not own the last transaction wins.
  always_comb begin
    owner = OWN_D;
    if (i_req && d_req) begin
      owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (i_req) begin
      owner = OWN_I;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = last_owner;

  always_comb begin
    owner = OWN_D;
    if (i_req && !d_req) begin
      owner = OWN_I;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory bus with
// WAIT timeout and sticky error. Round-robin via MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] TO_LAST = 4'(MEM_TIMEOUT - 1);

  state_t      r_state;
  owner_t      r_owner;
  owner_t      r_last;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_i_gnt;
  logic        r_d_gnt;
  logic        r_busy;
  logic        r_err;
  logic [3:0]  r_wait_cnt;

  owner_t      w_pick;
  logic        w_ack;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (r_last),
    .owner      (w_pick)
  );

  // A response is only accepted while waiting for one.
  assign w_ack = (r_state == ST_WAIT) && mem_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_I;
      r_last      <= OWN_I;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_gnt     <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_mem_req <= 1'b0;
      r_i_gnt   <= 1'b0;
      r_d_gnt   <= 1'b0;
      if (mem_rvalid && (r_state != ST_WAIT)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            r_owner     <= w_pick;
            r_last      <= w_pick;
            r_mem_we    <= (w_pick == OWN_D) && d_we;
            r_mem_addr  <= (w_pick == OWN_D) ? d_addr : i_addr;
            r_mem_wdata <= (w_pick == OWN_D) ? d_wdata : '0;
            r_mem_req   <= 1'b1;
            r_i_gnt     <= (w_pick == OWN_I);
            r_d_gnt     <= (w_pick == OWN_D);
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_busy     <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= ST_IDLE;
          end else if (r_wait_cnt == TO_LAST) begin
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_gnt     = r_i_gnt;
  assign d_gnt     = r_d_gnt;
  assign busy      = r_busy;
  assign err       = r_err;

  // Response data is forced to zero unless it belongs to this requester.
  assign i_rvalid = w_ack && (r_owner == OWN_I);
  assign d_rvalid = w_ack && (r_owner == OWN_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model (MEM_ARB_RR_EN aware).
module tb_mem_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy, err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transaction-level model: m_age = cycles since the command was accepted
  // (0 = no transaction, 1 = command cycle, n>=2 = (n-1)th cycle of waiting).
  int          m_age;
  bit          m_own_d, m_last_d, m_we, m_err;
  logic [31:0] m_addr, m_wdata;
  int          lat;

  function automatic bit pick_d(bit ir, bit dr, bit last_d);
    if (!ir) return 1'b1;
    if (!dr) return 1'b0;
`ifdef MEM_ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_age = 0; m_own_d = 0; m_last_d = 0; m_we = 0; m_err = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    if (mem_rvalid && m_age < 2) m_err = 1;
    if (m_age == 0) begin
      if (i_req || d_req) begin
        m_own_d  = pick_d(i_req, d_req, m_last_d);
        m_last_d = m_own_d;
        m_we     = m_own_d && d_we;
        m_addr   = m_own_d ? d_addr : i_addr;
        m_wdata  = m_own_d ? d_wdata : 32'h0;
        m_age    = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (mem_rvalid) begin
      m_age = 0;
    end else if (m_age - 1 == TO) begin
      m_err = 1;
      m_age = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic mem_auto();
    mem_rvalid = (m_age >= 2) && (m_age - 1 >= lat);
    mem_rdata  = $urandom;
  endtask

  task automatic check_cycle();
    bit iss, ack;
    #2;
    iss = (m_age == 1);
    ack = (m_age >= 2) && mem_rvalid;
    chk("mem_req",   32'(mem_req),   32'(iss));
    chk("mem_we",    32'(mem_we),    32'(m_we));
    chk("mem_addr",  mem_addr,       m_addr);
    chk("mem_wdata", mem_wdata,      m_wdata);
    chk("i_gnt",     32'(i_gnt),     32'(iss && !m_own_d));
    chk("d_gnt",     32'(d_gnt),     32'(iss && m_own_d));
    chk("i_rvalid",  32'(i_rvalid),  32'(ack && !m_own_d));
    chk("d_rvalid",  32'(d_rvalid),  32'(ack && m_own_d));
    chk("i_rdata",   i_rdata,        (ack && !m_own_d) ? mem_rdata : 32'h0);
    chk("d_rdata",   d_rdata,        (ack && m_own_d) ? mem_rdata : 32'h0);
    chk("busy",      32'(busy),      32'(m_age != 0));
    chk("err",       32'(err),       32'(m_err));
  endtask

  // Asynchronous assertion mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    rst = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; mem_rvalid = 0;
    #1;
    model_reset();
    chk("rst_busy_async", 32'(busy), 32'h0);
    chk("rst_mreq_async", 32'(mem_req), 32'h0);
    chk("rst_err_async",  32'(err), 32'h0);
    check_cycle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          gi, gd, rv_seen;
    int          ng, nb;
    logic [3:0]  order, exp_order;

    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_rvalid = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; lat = 1;
    model_reset();
    #2;
    do_reset();

    // Single fetch with a one-cycle memory response
    i_req = 1; i_addr = 32'h100; mem_rdata = $urandom; check_cycle();
    chk("f_gnt_c0", 32'(i_gnt), 32'h0);
    step(); check_cycle();
    chk("f_gnt_c1", 32'(i_gnt), 32'h1);
    chk("f_addr_c1", mem_addr, 32'h100);
    chk("f_we_c1", 32'(mem_we), 32'h0);
    step(); i_req = 0; mem_rvalid = 1; mem_rdata = 32'h00A00093; check_cycle();
    chk("f_rvalid_c2", 32'(i_rvalid), 32'h1);
    chk("f_rdata_c2", i_rdata, 32'h00A00093);
    step(); mem_rvalid = 0; mem_rdata = $urandom; check_cycle();
    chk("f_busy_c3", 32'(busy), 32'h0);

    // Store
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; check_cycle();
    step(); check_cycle();
    chk("s_mreq", 32'(mem_req), 32'h1);
    chk("s_we", 32'(mem_we), 32'h1);
    chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    chk("s_addr", mem_addr, 32'h200);
    step(); d_req = 0; mem_rvalid = 1; mem_rdata = $urandom; check_cycle();
    chk("s_d_rvalid", 32'(d_rvalid), 32'h1);
    chk("s_i_rvalid", 32'(i_rvalid), 32'h0);
    step(); mem_rvalid = 0; check_cycle();

    // Both requesters held for four transactions
    do_reset();
    lat = 1; i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h400; d_addr = 32'h800;
    order = '0; ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      mem_auto(); check_cycle();
      if (i_gnt || d_gnt) begin
        order[ng] = d_gnt;
        ng++;
      end
      step();
    end
    i_req = 0; d_req = 0;
    for (int c = 0; c < 4; c++) begin
      mem_auto(); check_cycle(); step();
    end
`ifdef MEM_ARB_RR_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    chk("arb_count", 32'(ng), 32'd4);
    chk("arb_order", 32'(order), 32'(exp_order));

    // Memory never answers: timeout then normal service
    do_reset();
    lat = 99; d_req = 1; d_we = 0; d_addr = 32'h300; nb = 0; rv_seen = 0; gd = 0;
    for (int c = 0; c < 40; c++) begin
      if (gd) d_req = 0;
      mem_auto(); check_cycle();
      rv_seen |= i_rvalid | d_rvalid;
      gd = d_gnt;
      if (busy) nb++;
      else if (nb > 0) break;
      step();
    end
    chk("to_busy_cycles", 32'(nb), 32'(TO + 1));
    chk("to_err", 32'(err), 32'h1);
    chk("to_no_rvalid", 32'(rv_seen), 32'h0);
    step();
    lat = 2; i_req = 1; i_addr = 32'h104; rv_seen = 0; gi = 0;
    for (int c = 0; c < 20 && !rv_seen; c++) begin
      if (gi) i_req = 0;
      mem_auto(); check_cycle();
      rv_seen |= i_rvalid;
      gi = i_gnt;
      step();
    end
    i_req = 0;
    chk("to_next_served", 32'(rv_seen), 32'h1);
    mem_auto(); check_cycle();

    // Reset during WAIT, late response afterwards
    do_reset();
    lat = 99; i_req = 1; i_addr = 32'h108; mem_auto(); check_cycle();
    step(); mem_auto(); check_cycle();
    step(); i_req = 0; mem_auto(); check_cycle();
    chk("rw_busy_wait", 32'(busy), 32'h1);
    do_reset();
    chk("rw_gnt_rst", 32'({i_gnt, d_gnt, i_rvalid, d_rvalid}), 32'h0);
    step(); mem_rvalid = 1; mem_rdata = $urandom; check_cycle();
    chk("rw_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
    step(); mem_rvalid = 0; check_cycle();
    chk("rw_err_stray", 32'(err), 32'h1);

    // Randomized traffic with reactive requesters and variable latency
    do_reset();
    gi = 0; gd = 0; lat = 1;
    for (int c = 0; c < 600; c++) begin
      if (gi) i_req = 0;
      else if (!i_req) begin
        if ($urandom_range(0, 3) == 0) begin i_req = 1; i_addr = $urandom; end
      end else if ($urandom_range(0, 19) == 0) i_req = 0;
      if (gd) d_req = 0;
      else if (!d_req) begin
        if ($urandom_range(0, 3) == 0) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
        end
      end else if ($urandom_range(0, 19) == 0) d_req = 0;
      if (m_age == 1) lat = ($urandom_range(0, 39) == 0) ? 30 : int'($urandom_range(1, 4));
      mem_auto();
      check_cycle();
      gi = (m_age == 1) && !m_own_d;
      gd = (m_age == 1) && m_own_d;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
